// File: rtl/ultrasonic_trigger_pkg.sv
// ultrasonic_pkg
// Shared definitions for the ultrasonic ranging block: the ranging FSM state
// type, default timing constants for a 50 MHz clk0, and the scale constants
// used to turn an echo width in cycles into centimetres.
//
// The centimetre conversion path is only built when ULTRASONIC_CM_EN is
// defined; the constants below are always present so that the bench and
// the car control logic can reference them either way.
//
// No ports (package).

package ultrasonic_pkg;

  // Ranging cycle states
  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  // Default timing at 50 MHz
  localparam int DEF_CNT_W          = 22;
  localparam int DEF_TRIG_CYCLES    = 500;      // 10 us trigger pulse
  localparam int DEF_PERIOD_CYCLES  = 3000000;  // 60 ms trig-to-trig spacing
  localparam int DEF_TIMEOUT_CYCLES = 1500000;  // 30 ms echo wait / max width
  localparam int DEF_NEAR_CYCLES    = 44117;    // near-obstacle threshold

  // dist_cm = echo_cycles * CM_MUL / CM_DIV at 50 MHz
  // (343 m/s round trip -> 17 cm per 50000 cycles)
  localparam int CM_MUL   = 17;
  localparam int CM_MUL_W = 5;
  localparam int CM_DIV   = 50000;
  localparam int CM_DIV_W = 16;
  localparam int DIST_W   = 10;
  localparam int DIST_MAX = 1023;

endpackage

// File: rtl/ultrasonic_trigger_if.sv
// ultrasonic_trigger_if
// Bundles the sensor pins and the result bus of the ultrasonic ranging
// block so the top and the car control logic can pass one handle around.
//
// Signals:
//   enable       car -> ranger  level, 1 = keep ranging continuously
//   echo         pin -> ranger  raw sensor echo (asynchronous)
//   trig         ranger -> pin  sensor trigger pulse
//   busy         ranger -> car  high whenever a ranging cycle is in progress
//   echo_cycles  ranger -> car  last measured echo width in clk0 cycles
//   meas_valid   ranger -> car  1-cycle pulse when echo_cycles updates
//   timeout      ranger -> car  1-cycle pulse when a cycle ends without echo
//   near         ranger -> car  last result valid and within near threshold
//   dist_cm      ranger -> car  distance in cm   (ULTRASONIC_CM_EN only)
//   dist_valid   ranger -> car  1-cycle pulse    (ULTRASONIC_CM_EN only)
//
// Modports: master = ranging block, slave = consumer / pin driver side.
// Optional feature macro: ULTRASONIC_CM_EN.

interface ultrasonic_trigger_if #(
  parameter int CNT_W = 22
);
  import ultrasonic_pkg::*;

  logic             enable;
  logic             echo;
  logic             trig;
  logic             busy;
  logic [CNT_W-1:0] echo_cycles;
  logic             meas_valid;
  logic             timeout;
  logic             near;
`ifdef ULTRASONIC_CM_EN
  logic [DIST_W-1:0] dist_cm;
  logic              dist_valid;
`endif

  modport master (
    input  enable, echo,
    output trig, busy, echo_cycles, meas_valid, timeout,
`ifdef ULTRASONIC_CM_EN
    output dist_cm, dist_valid,
`endif
    output near
  );

  modport slave (
    output enable, echo,
    input  trig, busy, echo_cycles, meas_valid, timeout,
`ifdef ULTRASONIC_CM_EN
    input  dist_cm, dist_valid,
`endif
    input  near
  );

endinterface

// File: rtl/ultrasonic_trigger_div.sv
// ultrasonic_div
// Iterative restoring unsigned divider, one quotient bit per clk0 cycle.
// A start pulse loads the operands (and restarts any division in flight);
// N_W cycles later quotient is updated and done pulses for one cycle.
// done therefore rises N_W+1 cycles after the cycle in which start is high.
//
// Ports:
//   clk0      in   clock, posedge
//   rst       in   synchronous active-high reset
//   start     in   load dividend/divisor and begin
//   dividend  in   N_W bits
//   divisor   in   D_W bits, must be non-zero
//   quotient  out  N_W bits, holds until the next completed division
//   done      out  1-cycle pulse when quotient updates
//
// Only instantiated when ULTRASONIC_CM_EN is defined.

module ultrasonic_div #(
  parameter int N_W = 27,
  parameter int D_W = 16
) (
  input  logic           clk0,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic [N_W-1:0] quotient,
  output logic           done
);

  localparam int C_W = $clog2(N_W + 1);

  logic [N_W-1:0] shreg;
  logic [D_W-1:0] rem;
  logic [D_W-1:0] dvs;
  logic [C_W-1:0] cnt;
  logic           running;

  logic [D_W:0]   trial;
  logic [D_W:0]   diff;
  logic           take;
  logic [N_W-1:0] next_sh;
  logic [D_W-1:0] next_rem;

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits. Since rem < divisor, both the restored
  // and the reduced remainder fit back into D_W bits.
  always_comb begin
    trial    = {rem, shreg[N_W-1]};
    diff     = trial - {1'b0, dvs};
    take     = (trial >= {1'b0, dvs});
    next_sh  = {shreg[N_W-2:0], take};
    next_rem = take ? diff[D_W-1:0] : trial[D_W-1:0];
  end

  // shreg starts as the dividend and fills with quotient bits from the right
  always_ff @(posedge clk0) begin
    if (rst) begin
      shreg    <= '0;
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      running  <= 1'b0;
      quotient <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg   <= dividend;
        rem     <= '0;
        dvs     <= divisor;
        cnt     <= C_W'(N_W);
        running <= 1'b1;
      end else if (running) begin
        shreg <= next_sh;
        rem   <= next_rem;
        cnt   <= cnt - C_W'(1);
        if (cnt == C_W'(1)) begin
          running  <= 1'b0;
          quotient <= next_sh;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ultrasonic_trigger.sv
// ultrasonic_trigger
// Initiator side of an HC-SR04-style ranging sensor. Issues a periodic trig
// pulse, waits for the echo, times its width in clk0 cycles and publishes
// one result (or a timeout) per ranging cycle for the motor state machine.
//
// Ports:
//   clk0  in  system clock, posedge
//   rst   in  synchronous active-high reset
//   bus   ultrasonic_trigger_if.master
//         in : enable, echo
//         out: trig, busy, echo_cycles, meas_valid, timeout, near
//              (+ dist_cm, dist_valid with ULTRASONIC_CM_EN)
//
// Optional feature macro: ULTRASONIC_CM_EN adds a centimetre conversion of
// each valid measurement through a sequential divider (ultrasonic_div).

module ultrasonic_trigger
  import ultrasonic_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int NEAR_CYCLES    = DEF_NEAR_CYCLES
) (
  input  logic             clk0,
  input  logic             rst,
  ultrasonic_trigger_if.master bus
);

  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_MAX   = CNT_W'(PERIOD_CYCLES);
  localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] NEAR_MAX     = CNT_W'(NEAR_CYCLES);

  state_t           state;
  logic             echo_m;
  logic             echo_s;
  logic             echo_d;
  logic             rise;
  logic             fall;

  logic [CNT_W-1:0] trig_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] width_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] echo_cycles_q;

  logic             trig_q;
  logic             busy_q;
  logic             meas_valid_q;
  logic             timeout_q;
  logic             near_q;

  // Two-flop synchronizer plus one history flop. Rise and fall are both
  // taken from the synchronized pair, so they share the same delay and the
  // measured width equals the pin width in cycles.
  always_ff @(posedge clk0) begin
    if (rst) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
      echo_d <= 1'b0;
    end else begin
      echo_m <= bus.echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  assign rise = echo_s & ~echo_d;
  assign fall = ~echo_s & echo_d;

  // Ranging FSM with registered outputs. The period counter runs from every
  // TRIG entry and HOLDOFF releases on its registered value PERIOD-1, which
  // places the next trig rise exactly PERIOD_CYCLES after the previous one.
  // wait_cnt is compared one below TIMEOUT because it is incremented on the
  // same edge; the timeout pulse thus lands TIMEOUT cycles after trig falls.
  always_ff @(posedge clk0) begin
    if (rst) begin
      state         <= IDLE;
      trig_q        <= 1'b0;
      busy_q        <= 1'b0;
      meas_valid_q  <= 1'b0;
      timeout_q     <= 1'b0;
      near_q        <= 1'b0;
      echo_cycles_q <= '0;
      trig_cnt      <= '0;
      wait_cnt      <= '0;
      width_cnt     <= '0;
      period_cnt    <= '0;
    end else begin
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;

      if (state != IDLE && period_cnt != PERIOD_MAX) begin
        period_cnt <= period_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (bus.enable) begin
            state      <= TRIG;
            trig_q     <= 1'b1;
            busy_q     <= 1'b1;
            period_cnt <= '0;
            trig_cnt   <= '0;
            wait_cnt   <= '0;
          end
        end

        TRIG: begin
          if (trig_cnt == TRIG_LAST) begin
            trig_q <= 1'b0;
            state  <= WAIT_RISE;
          end else begin
            trig_cnt <= trig_cnt + CNT_W'(1);
          end
        end

        // An echo already high on entry produces no rise and times out.
        WAIT_RISE: begin
          if (rise) begin
            state     <= MEASURE;
            width_cnt <= CNT_W'(1);
          end else if (wait_cnt == TIMEOUT_LAST) begin
            timeout_q <= 1'b1;
            near_q    <= 1'b0;
            state     <= HOLDOFF;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        // Width limit wins over a fall on the same edge.
        MEASURE: begin
          if (width_cnt >= TIMEOUT_MAX) begin
            echo_cycles_q <= TIMEOUT_MAX;
            timeout_q     <= 1'b1;
            near_q        <= 1'b0;
            state         <= HOLDOFF;
          end else if (fall) begin
            echo_cycles_q <= width_cnt;
            meas_valid_q  <= 1'b1;
            near_q        <= (width_cnt <= NEAR_MAX);
            state         <= HOLDOFF;
          end else if (echo_s) begin
            width_cnt <= width_cnt + CNT_W'(1);
          end
        end

        HOLDOFF: begin
          if (period_cnt >= PERIOD_LAST) begin
            if (bus.enable) begin
              state      <= TRIG;
              trig_q     <= 1'b1;
              period_cnt <= '0;
              trig_cnt   <= '0;
              wait_cnt   <= '0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end

        default: begin
          state  <= IDLE;
          trig_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trig        = trig_q;
  assign bus.busy        = busy_q;
  assign bus.echo_cycles = echo_cycles_q;
  assign bus.meas_valid  = meas_valid_q;
  assign bus.timeout     = timeout_q;
  assign bus.near        = near_q;

`ifdef ULTRASONIC_CM_EN
  // The product needs CNT_W+5 bits, so the divider takes CNT_W+5 step cycles
  // plus one load cycle: dist_valid follows meas_valid by CNT_W+6 cycles.
  localparam int PROD_W = CNT_W + CM_MUL_W;

  logic [PROD_W-1:0] product;
  logic [PROD_W-1:0] quotient;
  logic              div_done;

  assign product = PROD_W'(echo_cycles_q) * PROD_W'(CM_MUL);

  ultrasonic_div #(
    .N_W (PROD_W),
    .D_W (CM_DIV_W)
  ) u_div (
    .clk0     (clk0),
    .rst      (rst),
    .start    (meas_valid_q),
    .dividend (product),
    .divisor  (CM_DIV_W'(CM_DIV)),
    .quotient (quotient),
    .done     (div_done)
  );

  assign bus.dist_cm    = (|quotient[PROD_W-1:DIST_W]) ? DIST_W'(DIST_MAX)
                                                       : quotient[DIST_W-1:0];
  assign bus.dist_valid = div_done;
`endif

endmodule

// File: tb/tb_ultrasonic_trigger.sv
// tb_ultrasonic_trigger
// Self-checking bench for ultrasonic_trigger with shortened timing
// (TRIG 10, PERIOD 200, TIMEOUT 100, NEAR 40). Each ranging cycle is
// described by a mode, echo delay and echo width; the expected outcome is
// derived from those numbers alone. With ULTRASONIC_CM_EN a second
// instance with a long timeout checks the centimetre conversion.

module tb_ultrasonic_trigger;
  import ultrasonic_pkg::*;

  localparam int CNT_W     = 22;
  localparam int TRIG_C    = 10;
  localparam int PERIOD_C  = 200;
  localparam int TIMEOUT_C = 100;
  localparam int NEAR_C    = 40;

  typedef struct {
    int cyc;
    bit valid;
    bit tmo;
    int value;
    bit near;
  } ev_t;

  logic clk0 = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_ec = 0;
  int   prev_rise = -1;
  ev_t  evq[$];

  always #5 clk0 = ~clk0;
  always @(posedge clk0) cyc <= cyc + 1;

  ultrasonic_trigger_if #(.CNT_W(CNT_W)) bus ();

  ultrasonic_trigger #(
    .CNT_W          (CNT_W),
    .TRIG_CYCLES    (TRIG_C),
    .PERIOD_CYCLES  (PERIOD_C),
    .TIMEOUT_CYCLES (TIMEOUT_C),
    .NEAR_CYCLES    (NEAR_C)
  ) dut (
    .clk0 (clk0),
    .rst  (rst),
    .bus  (bus)
  );

`ifdef ULTRASONIC_CM_EN
  localparam int CM_W = 44117;

  ultrasonic_trigger_if #(.CNT_W(CNT_W)) bus2 ();

  ultrasonic_trigger #(
    .CNT_W          (CNT_W),
    .TRIG_CYCLES    (TRIG_C),
    .PERIOD_CYCLES  (100000),
    .TIMEOUT_CYCLES (50000),
    .NEAR_CYCLES    (NEAR_C)
  ) dut2 (
    .clk0 (clk0),
    .rst  (rst),
    .bus  (bus2)
  );
`endif

  // Log every result pulse with the cycle it became visible
  always @(negedge clk0) begin
    if (bus.meas_valid || bus.timeout)
      evq.push_back('{cyc, bus.meas_valid, bus.timeout, int'(bus.echo_cycles), bus.near});
  end

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outcome of a ranging cycle from its stimulus description
  function automatic void expectFor(input int mode, input int width, output bit v,
                                    output bit t, output int val, output bit nr);
    if (mode != 0) begin
      v = 0; t = 1; val = last_ec; nr = 0;
    end else if (width >= TIMEOUT_C) begin
      v = 0; t = 1; val = TIMEOUT_C; nr = 0;
    end else begin
      v = 1; t = 0; val = width; nr = (width <= NEAR_C);
    end
  endfunction

  task automatic waitTrigRise(output int t);
    int n = 0;
    while (bus.trig !== 1'b1 && n < 500) begin
      @(negedge clk0);
      n++;
    end
    checkOutput("trig_rise_seen", bus.trig, 1);
    t = cyc;
  endtask

  task automatic waitEvent(output ev_t ev);
    int n = 0;
    while (evq.size() == 0 && n < 300) begin
      @(negedge clk0);
      n++;
    end
    checkOutput("outcome_seen", evq.size() > 0, 1);
    if (evq.size() > 0) ev = evq.pop_front();
    else ev = '{0, 0, 0, -1, 0};
  endtask

  // mode 0: echo pulse of 'width' cycles starting 'dly' cycles after trig falls
  // mode 1: no echo at all
  // mode 2: echo already high before trig, released after the timeout
  task automatic applyStimulus(input int mode, input int dly, input int width, input bit drop_en);
    int  t_rise, t_fall, p_fall, hi, e_val;
    bit  e_valid, e_tmo, e_near;
    ev_t ev;
    if (mode == 2) bus.echo = 1'b1;
    waitTrigRise(t_rise);
    checkOutput("stray_pulses", evq.size(), 0);
    checkOutput("echo_cycles_hold", int'(bus.echo_cycles), last_ec);
    if (prev_rise >= 0) checkOutput("trig_spacing", t_rise - prev_rise, PERIOD_C);
    prev_rise = t_rise;
    hi = 0;
    while (bus.trig === 1'b1 && hi < 50) begin
      hi++;
      @(negedge clk0);
    end
    checkOutput("trig_high_cycles", hi, TRIG_C);
    t_fall = cyc;
    p_fall = 0;
    if (mode == 0) begin
      repeat (dly) @(posedge clk0);
      #1 bus.echo = 1'b1;
      for (int i = 0; i < width; i++) begin
        @(posedge clk0);
        #1;
        if (drop_en && i == 4) bus.enable = 1'b0;
      end
      bus.echo = 1'b0;
      p_fall = cyc;
    end
    waitEvent(ev);
    if (mode == 2) bus.echo = 1'b0;
    expectFor(mode, width, e_valid, e_tmo, e_val, e_near);
    checkOutput("meas_valid", ev.valid, e_valid);
    checkOutput("timeout", ev.tmo, e_tmo);
    checkOutput("echo_cycles", ev.value, e_val);
    checkOutput("near", ev.near, e_near);
    if (e_valid) checkOutput("fall_to_valid_latency", ev.cyc - p_fall, 3);
    else if (mode != 0) checkOutput("trig_fall_to_timeout", ev.cyc - t_fall, TIMEOUT_C);
    last_ec = e_val;
  endtask

  initial begin : main
    int t0, t1, n, cnt;
    rst = 1'b1;
    bus.enable = 1'b1;
    bus.echo = 1'b0;
`ifdef ULTRASONIC_CM_EN
    bus2.enable = 1'b0;
    bus2.echo = 1'b0;
`endif
    @(negedge clk0);
    @(negedge clk0);
    checkOutput("reset_trig", bus.trig, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_meas_valid", bus.meas_valid, 0);
    checkOutput("reset_timeout", bus.timeout, 0);
    checkOutput("reset_near", bus.near, 0);
    checkOutput("reset_echo_cycles", bus.echo_cycles, 0);
    t0 = cyc;
    rst = 1'b0;
    waitTrigRise(t1);
    checkOutput("enable_to_trig", t1 - t0, 1);

    $display("[TB] directed cycles");
    applyStimulus(0, 20, 30, 0);
    applyStimulus(0, 20, 60, 0);
    applyStimulus(0, 20, 40, 0);
    applyStimulus(0, 15, 41, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 20, 150, 0);
    applyStimulus(2, 0, 0, 0);

    $display("[TB] random cycles");
    for (int k = 0; k < 8; k++)
      applyStimulus(0, int'($urandom_range(1, 40)), int'($urandom_range(1, 90)), 0);

    $display("[TB] enable drop during measurement");
    applyStimulus(0, 20, 30, 1);
    n = 0;
    while (bus.busy !== 1'b0 && n < 400) begin
      @(negedge clk0);
      n++;
    end
    checkOutput("busy_after_disable", bus.busy, 0);
    cnt = 0;
    repeat (300) begin
      @(negedge clk0);
      if (bus.trig) cnt++;
    end
    checkOutput("trig_after_disable", cnt, 0);
    checkOutput("pulses_while_idle", evq.size(), 0);

    t0 = cyc;
    bus.enable = 1'b1;
    waitTrigRise(t1);
    checkOutput("reenable_to_trig", t1 - t0, 1);
    prev_rise = -1;
    applyStimulus(0, 10, 25, 0);

    $display("[TB] reset during trig");
    waitTrigRise(t1);
    repeat (3) @(negedge clk0);
    rst = 1'b1;
    @(negedge clk0);
    checkOutput("midreset_trig", bus.trig, 0);
    checkOutput("midreset_busy", bus.busy, 0);
    checkOutput("midreset_meas_valid", bus.meas_valid, 0);
    checkOutput("midreset_timeout", bus.timeout, 0);
    checkOutput("midreset_near", bus.near, 0);
    checkOutput("midreset_echo_cycles", bus.echo_cycles, 0);
    rst = 1'b0;
    prev_rise = -1;
    last_ec = 0;
    evq.delete();
    applyStimulus(0, 5, 50, 0);
    applyStimulus(0, 8, 12, 0);

`ifdef ULTRASONIC_CM_EN
    begin : dist_test
      int m_cyc, d_cyc, d_cnt, d_val, d_exp;
      $display("[TB] centimetre conversion");
      d_exp = (CM_W * CM_MUL) / CM_DIV;
      if (d_exp > DIST_MAX) d_exp = DIST_MAX;
      bus2.enable = 1'b1;
      n = 0;
      while (bus2.trig !== 1'b1 && n < 50) begin
        @(negedge clk0);
        n++;
      end
      checkOutput("cm_trig_rise", bus2.trig, 1);
      n = 0;
      while (bus2.trig === 1'b1 && n < 50) begin
        @(negedge clk0);
        n++;
      end
      bus2.enable = 1'b0;
      repeat (5) @(posedge clk0);
      #1 bus2.echo = 1'b1;
      repeat (CM_W) @(posedge clk0);
      #1 bus2.echo = 1'b0;
      n = 0;
      while (bus2.meas_valid !== 1'b1 && n < 20) begin
        @(negedge clk0);
        n++;
      end
      checkOutput("cm_meas_valid", bus2.meas_valid, 1);
      checkOutput("cm_echo_cycles", bus2.echo_cycles, CM_W);
      m_cyc = cyc;
      d_cnt = 0;
      d_cyc = -1;
      d_val = -1;
      repeat (60) begin
        @(negedge clk0);
        if (bus2.dist_valid) begin
          d_cnt++;
          if (d_cyc < 0) begin
            d_cyc = cyc;
            d_val = int'(bus2.dist_cm);
          end
        end
      end
      checkOutput("cm_dist_valid_count", d_cnt, 1);
      checkOutput("cm_dist_latency", d_cyc - m_cyc, CNT_W + 6);
      checkOutput("cm_dist_cm", d_val, d_exp);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ultrasonic_trigger.md
Name: ultrasonic_trigger

Overview:
- Initiator side of the HC-SR04-style ranging interface on the smart car.
- Issues the periodic trig pulse, waits for the sensor's echo, times its width in clk0 cycles and publishes one result per ranging cycle.
- The motor state machine consumes the measurement and near flag instead of timing raw echo itself.
- Sits between the sensor pins and the car control logic, in the clk0 domain.

Parameters:
- CNT_W, 22: width of all cycle counters and echo_cycles.
- TRIG_CYCLES, 500: trig high time in clk0 cycles (10 us at 50 MHz).
- PERIOD_CYCLES, 3000000: minimum trig-rise to trig-rise spacing (60 ms).
- TIMEOUT_CYCLES, 1500000: maximum wait for echo rise, and maximum echo width (30 ms).
- NEAR_CYCLES, 44117: near threshold; echo_cycles <= NEAR_CYCLES means obstacle near.

Ports:
- clk0  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = keep ranging continuously.
- echo  in  1  raw sensor echo, asynchronous.
- trig  out  1  sensor trigger pulse.
- busy  out  1  high in any state other than IDLE.
- echo_cycles  out  CNT_W  last measured echo width; holds until the next result.
- meas_valid  out  1  1-cycle pulse when echo_cycles updates.
- timeout  out  1  1-cycle pulse when a cycle ends without a valid echo.
- near  out  1  registered (echo_cycles <= NEAR_CYCLES) && last result valid.

Behaviour:
- Reset: one clock with rst=1 forces the following values:
  - state=IDLE; trig, busy, meas_valid, timeout, near = 0; echo_cycles = 0.
  - Synchronizer flops and all counters = 0.
  - Applies mid-operation too: trig drops on the same edge.
- echo passes through a 2-flop synchronizer, giving echo_s, plus an echo_d history flop.
  - rise = echo_s & ~echo_d; fall = ~echo_s & echo_d.
  - Both edges see equal delay, so the measured width is exact in cycles.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE: on enable=1, go to TRIG at the next edge and clear the period counter.
- TRIG:
  - trig=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE.
  - On entry, clear the wait counter.
- Period counter: increments every cycle from TRIG entry and saturates at PERIOD_CYCLES.
- WAIT_RISE:
  - On rise, go to MEASURE with the width counter set to 1.
  - Else the wait counter increments.
  - When the wait counter reaches TIMEOUT_CYCLES: timeout pulse, go to HOLDOFF.
  - echo already high on entry, with no rise, counts as no echo and ends in timeout.
- MEASURE:
  - While echo_s=1, the width counter increments.
  - On fall: echo_cycles <= counter, meas_valid pulse, near updated, go to HOLDOFF.
  - If the counter reaches TIMEOUT_CYCLES before fall, this takes priority:
    - echo_cycles <= TIMEOUT_CYCLES; timeout pulse, no meas_valid; near <= 0.
    - Go to HOLDOFF.
- HOLDOFF:
  - Waits until the period counter reaches PERIOD_CYCLES-1.
  - Then goes to TRIG if enable=1, else to IDLE.
  - Guarantees trig rises are spaced at least PERIOD_CYCLES apart.
- enable dropping mid-cycle does not abort the cycle; it completes, then goes to IDLE.
- meas_valid and timeout are never high in the same cycle; each pulses at most once per ranging cycle.
- Latency:
  - enable rise to trig rise: 1 cycle.
  - Echo fall on the pin to meas_valid: 3 cycles (2 sync + 1 register).
- busy = (state != IDLE), registered.

Optional Feature:
- Macro ULTRASONIC_CM_EN.
- Defined:
  - Adds output dist_cm (10 bits) and dist_valid (1-cycle pulse).
  - After each meas_valid, computes dist_cm = echo_cycles*17/50000, truncated and saturated to 1023.
  - Uses an iterative restoring divider, one quotient bit per clk0 cycle.
  - dist_valid fires CNT_W+6 cycles after meas_valid, unless the next meas_valid comes first; that restarts the divider.
  - Reset clears both outputs.
- Undefined: the ports and the divider are absent; the rest of the behaviour is identical.

Decomposition:
- Package ultrasonic_pkg holds:
  - The state enum: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
  - Default timing constants at 50 MHz and the cm scale constants 17 and 50000.
- Sub-module ultrasonic_div: sequential unsigned divider, only instantiated under ULTRASONIC_CM_EN.

Test Plan:
- Bench parameters: TRIG_CYCLES=10, PERIOD_CYCLES=200, TIMEOUT_CYCLES=100, NEAR_CYCLES=40.
- enable=1 from reset, echo rises 20 cycles after trig falls and stays high 30 cycles.
  - Required: trig high exactly 10 cycles; echo_cycles=30, meas_valid once, near=1, timeout never.
  - Required: next trig rise exactly 200 cycles after the first.
- Echo width 60: echo_cycles=60, near=0; an echo width exactly 40 gives near=1 (boundary).
- No echo: timeout pulse 100 cycles after trig falls; echo_cycles unchanged; next trig still at 200-cycle spacing.
- Echo stuck high (width > 100): timeout pulse, echo_cycles=100, near=0, no meas_valid.
- Echo already high before trig: no false rise; timeout fires.
- Reset and enable:
  - Deassert enable during MEASURE: result still published, then busy=0, no further trig.
  - Assert rst while trig=1: trig=0 and all outputs 0 the cycle after.
- With ULTRASONIC_CM_EN and default scaling, echo_cycles=44117: dist_cm=14, dist_valid pulses once.
